sdram_rd_arb: RTL and testbench

SDRAM_RD_ARB -- requirements
Module: sdram_rd_arb

---
 rtl/oric_mem_pkg.sv | 28 ++
 rtl/sdram_rd_arb_if.sv | 34 +++
 rtl/sdram_rd_arb_req_latch.sv | 47 ++++
 rtl/sdram_rd_arb.sv | 134 +++++++++++++
 tb/tb_sdram_rd_arb.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oric_mem_pkg.sv
// Shared constants and types for the SDRAM read arbiter.
package oric_mem_pkg;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned CNT_W   = 4;

    typedef logic req_idx_t;
    localparam req_idx_t TAPE = 1'b0;
    localparam req_idx_t LDR  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef logic [CNT_W-1:0] lat_cnt_t;

    // Counter preload for a given read latency, clamped to the legal range.
    function automatic lat_cnt_t lat_load(input int unsigned lat);
        if (lat < LAT_MIN) return '0;
        if (lat > LAT_MAX) return lat_cnt_t'(LAT_MAX - 1);
        return lat_cnt_t'(lat - 1);
    endfunction

endpackage

// File: rtl/sdram_rd_arb_if.sv
// Requester and SDRAM read-port signals of the read arbiter.
interface sdram_rd_arb_if #(
    parameter int unsigned AW = 25
) ();

    logic          tape_rd;
    logic [AW-1:0] tape_addr;
    logic          tape_en;
    logic [7:0]    tape_data;
    logic          tape_ack;

    logic          ldr_rd;
    logic [AW-1:0] ldr_addr;
    logic [7:0]    ldr_data;
    logic          ldr_ack;

    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_dout;
    logic          busy;

    // Arbiter side.
    modport slave (
        input  tape_rd, tape_addr, tape_en, ldr_rd, ldr_addr, mem_dout,
        output tape_data, tape_ack, ldr_data, ldr_ack, mem_addr, mem_rd, busy
    );

    // Requesters and memory side.
    modport master (
        output tape_rd, tape_addr, tape_en, ldr_rd, ldr_addr, mem_dout,
        input  tape_data, tape_ack, ldr_data, ldr_ack, mem_addr, mem_rd, busy
    );

endinterface

// File: rtl/sdram_rd_arb_req_latch.sv
// Per-requester pending flag and address latch.
module rd_req_latch #(
    parameter int unsigned AW = 25
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en_i,
    input  logic          rd_i,
    input  logic [AW-1:0] addr_i,
    input  logic          clr_i,
    output logic          req_o,
    output logic [AW-1:0] req_addr_o
);

    logic          pending_q, pending_d;
    logic [AW-1:0] addr_q, addr_d;

    // Next pending/address: disable drops, issue clears, a pulse only sets an empty latch.
    always_comb begin
        pending_d = pending_q;
        addr_d    = addr_q;
        if (!en_i) begin
            pending_d = 1'b0;
        end else if (clr_i) begin
            pending_d = 1'b0;
        end else if (rd_i && !pending_q) begin
            pending_d = 1'b1;
            addr_d    = addr_i;
        end
    end

    // Latch registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            pending_q <= pending_d;
            addr_q    <= addr_d;
        end
    end

    // A fresh pulse is presented at once so an idle arbiter can grant it in the same cycle.
    assign req_o      = en_i && (pending_q || rd_i);
    assign req_addr_o = pending_q ? addr_q : addr_i;

endmodule

// File: rtl/sdram_rd_arb.sv
// Round-robin SDRAM read arbiter for the cassette and image-loader requesters.
module sdram_rd_arb
    import oric_mem_pkg::*;
#(
    parameter int unsigned AW  = 25,
    parameter int unsigned LAT = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    sdram_rd_arb_if.slave bus
);

    localparam lat_cnt_t LAT_LOAD = lat_load(LAT);

    arb_state_e    state_q;
    req_idx_t      grant_q;
    req_idx_t      rr_q;
    lat_cnt_t      cnt_q;
    logic          mem_rd_q;
    logic [AW-1:0] mem_addr_q;
    logic [7:0]    tape_data_q;
    logic [7:0]    ldr_data_q;
    logic          tape_ack_q;
    logic          ldr_ack_q;
    logic          busy_q;

    logic          tape_req, ldr_req, any_req;
    logic          tape_clr, ldr_clr;
    logic [AW-1:0] tape_req_addr, ldr_req_addr;
    req_idx_t      pick;

    assign tape_clr = (state_q == ISSUE) && (grant_q == TAPE);
    assign ldr_clr  = (state_q == ISSUE) && (grant_q == LDR);

    rd_req_latch #(.AW(AW)) u_tape_latch (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (bus.tape_en),
        .rd_i       (bus.tape_rd),
        .addr_i     (bus.tape_addr),
        .clr_i      (tape_clr),
        .req_o      (tape_req),
        .req_addr_o (tape_req_addr)
    );

    rd_req_latch #(.AW(AW)) u_ldr_latch (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (1'b1),
        .rd_i       (bus.ldr_rd),
        .addr_i     (bus.ldr_addr),
        .clr_i      (ldr_clr),
        .req_o      (ldr_req),
        .req_addr_o (ldr_req_addr)
    );

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        any_req = tape_req || ldr_req;
        if (tape_req && ldr_req) begin
            pick = rr_q;
        end else if (ldr_req) begin
            pick = LDR;
        end else begin
            pick = TAPE;
        end
    end

    // Access sequencer; mem_rd/ack are set on entry so they appear in ISSUE and the ack cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= TAPE;
            rr_q        <= LDR;
            cnt_q       <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            tape_data_q <= '0;
            ldr_data_q  <= '0;
            tape_ack_q  <= 1'b0;
            ldr_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mem_rd_q   <= 1'b0;
            tape_ack_q <= 1'b0;
            ldr_ack_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    busy_q <= any_req;
                    if (any_req) begin
                        grant_q    <= pick;
                        mem_addr_q <= (pick == LDR) ? ldr_req_addr : tape_req_addr;
                        mem_rd_q   <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= LAT_LOAD;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (grant_q == LDR) begin
                            ldr_data_q <= bus.mem_dout;
                        end else begin
                            tape_data_q <= bus.mem_dout;
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (grant_q == LDR) begin
                        ldr_ack_q <= 1'b1;
                    end else begin
                        tape_ack_q <= 1'b1;
                    end
                    rr_q    <= ~grant_q;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.tape_data = tape_data_q;
    assign bus.ldr_data  = ldr_data_q;
    assign bus.tape_ack  = tape_ack_q;
    assign bus.ldr_ack   = ldr_ack_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sdram_rd_arb.sv
// Self-checking bench for sdram_rd_arb: transaction-timeline model plus directed scenarios.
module tb_sdram_rd_arb;

    localparam int unsigned AW  = 25;
    localparam int unsigned LAT = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sdram_rd_arb_if #(.AW(AW)) bus ();

    sdram_rd_arb #(.AW(AW), .LAT(LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // stimulus for the cycle about to be clocked
    logic          s_rst_n = 1'b0;
    logic          s_trd = 1'b0, s_lrd = 1'b0, s_ten = 1'b0;
    logic [AW-1:0] s_taddr = '0, s_laddr = '0;

    // memory model: data scheduled LAT cycles after an observed mem_rd
    logic [7:0] sched_d [32];
    bit         sched_v [32];

    // reference model: requester pending state plus position inside the current access
    bit            m_pend [2];
    logic [AW-1:0] m_addr [2];
    bit            m_rr, m_act, m_who;
    int            m_k;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_data [2];

    // observations for directed scenarios
    int            o_nrd, o_first_rd, o_last_rd, o_min_gap, o_ntack, o_nlack, o_tack_cyc;
    logic [AW-1:0] o_rd_addr;
    bit            o_who [$];

    function automatic logic [7:0] mem_fn(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hB5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit el_t, el_l, do_g, g;
        logic [AW-1:0] ga;
        if (!s_rst_n) begin
            m_pend[0] = 0; m_pend[1] = 0; m_addr[0] = '0; m_addr[1] = '0;
            m_rr = 1; m_act = 0; m_who = 0; m_k = 0;
            e_addr = '0; e_data[0] = '0; e_data[1] = '0;
            return;
        end
        if (m_act && m_k == LAT) e_data[m_who] = bus.mem_dout;
        if (m_act && m_k == LAT + 1) m_rr = !m_who;
        el_t = (m_pend[0] || s_trd) && s_ten;
        el_l = m_pend[1] || s_lrd;
        do_g = (!m_act || m_k == LAT + 2) && (el_t || el_l);
        g    = (el_t && el_l) ? m_rr : el_l;
        ga   = g ? (m_pend[1] ? m_addr[1] : s_laddr) : (m_pend[0] ? m_addr[0] : s_taddr);
        if (!s_ten) m_pend[0] = 0;
        else if (m_act && m_k == 0 && m_who == 0) m_pend[0] = 0;
        else if (s_trd && !m_pend[0]) begin m_pend[0] = 1; m_addr[0] = s_taddr; end
        if (m_act && m_k == 0 && m_who == 1) m_pend[1] = 0;
        else if (s_lrd && !m_pend[1]) begin m_pend[1] = 1; m_addr[1] = s_laddr; end
        if (m_act) begin
            if (m_k == LAT + 2) m_act = 0;
            else m_k++;
        end
        if (do_g) begin m_act = 1; m_k = 0; m_who = g; e_addr = ga; end
    endtask

    task automatic compare();
        chk("mem_rd",    32'(bus.mem_rd),    32'(m_act && m_k == 0));
        chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
        chk("tape_ack",  32'(bus.tape_ack),  32'(m_act && m_k == LAT + 2 && m_who == 0));
        chk("ldr_ack",   32'(bus.ldr_ack),   32'(m_act && m_k == LAT + 2 && m_who == 1));
        chk("tape_data", 32'(bus.tape_data), 32'(e_data[0]));
        chk("ldr_data",  32'(bus.ldr_data),  32'(e_data[1]));
        chk("busy",      32'(bus.busy),      32'(m_act));
    endtask

    task automatic observe();
        if (bus.mem_rd === 1'b1) begin
            o_nrd++;
            if (o_first_rd < 0) o_first_rd = cyc;
            if (o_last_rd >= 0 && cyc - o_last_rd < o_min_gap) o_min_gap = cyc - o_last_rd;
            o_last_rd = cyc;
            o_rd_addr = bus.mem_addr;
        end
        if (bus.tape_ack === 1'b1) begin o_ntack++; o_tack_cyc = cyc; o_who.push_back(1'b0); end
        if (bus.ldr_ack === 1'b1) begin o_nlack++; o_who.push_back(1'b1); end
    endtask

    task automatic clr_obs();
        o_nrd = 0; o_first_rd = -1; o_last_rd = -1; o_min_gap = 1000;
        o_ntack = 0; o_nlack = 0; o_tack_cyc = -1; o_rd_addr = '0;
        o_who.delete();
    endtask

    // Drive one cycle of stimulus, advance the model, clock, then check.
    task automatic tick();
        int unsigned slot;
        reset_n       = s_rst_n;
        bus.tape_rd   = s_trd;
        bus.tape_addr = s_taddr;
        bus.tape_en   = s_ten;
        bus.ldr_rd    = s_lrd;
        bus.ldr_addr  = s_laddr;
        slot = cyc % 32;
        if (sched_v[slot]) begin
            bus.mem_dout  = sched_d[slot];
            sched_v[slot] = 0;
        end else begin
            bus.mem_dout = 8'($urandom);
        end
        if (bus.mem_rd === 1'b1) begin
            slot = (cyc + LAT) % 32;
            sched_v[slot] = 1;
            sched_d[slot] = mem_fn(bus.mem_addr);
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare();
        observe();
        s_trd = 1'b0;
        s_lrd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        s_rst_n = 1'b0;
        idle(n);
        s_rst_n = 1'b1;
    endtask

    int t0, nreq;

    initial begin
        for (int i = 0; i < 32; i++) sched_v[i] = 0;
        clr_obs();

        // reset values
        do_reset(3);
        chk("rst_outputs", 32'({bus.mem_rd, bus.tape_ack, bus.ldr_ack, bus.busy}), 32'h0);
        chk("rst_addr_data", 32'({bus.mem_addr[7:0], bus.tape_data, bus.ldr_data}), 32'h0);

        // single cassette read, uncontended
        s_ten = 1'b1;
        idle(2);
        clr_obs();
        t0 = cyc;
        s_trd = 1'b1; s_taddr = 25'h000010;
        tick();
        idle(10);
        chk("t34_rd_cycle", 32'(o_first_rd - t0), 32'd1);
        chk("t34_rd_addr", 32'(o_rd_addr), 32'h10);
        chk("t34_ack_cycle", 32'(o_tack_cyc - t0), 32'(LAT + 3));
        chk("t34_data", 32'(bus.tape_data), 32'hA5);
        chk("t34_model_data", 32'(e_data[0]), 32'hA5);
        chk("t34_nrd", 32'(o_nrd), 32'd1);

        // simultaneous requests after reset: loader first
        do_reset(2);
        clr_obs();
        s_trd = 1'b1; s_taddr = 25'h000100;
        s_lrd = 1'b1; s_laddr = 25'h000200;
        tick();
        idle(16);
        chk("t35_nrd", 32'(o_nrd), 32'd2);
        chk("t35_gap_ge4", 32'(o_min_gap >= 4), 32'd1);
        chk("t35_nacks", 32'(o_who.size()), 32'd2);
        if (o_who.size() >= 2) begin
            chk("t35_first_ldr", 32'(o_who[0]), 32'd1);
            chk("t35_second_tape", 32'(o_who[1]), 32'd0);
        end

        // both requesters re-request on every ack
        do_reset(2);
        clr_obs();
        s_trd = 1'b1; s_taddr = AW'($urandom);
        s_lrd = 1'b1; s_laddr = AW'($urandom);
        nreq = 2;
        tick();
        for (int i = 0; i < 200 && o_who.size() < 20; i++) begin
            if (bus.tape_ack === 1'b1 && o_who.size() < 20) begin
                s_trd = 1'b1; s_taddr = AW'($urandom); nreq++;
            end
            if (bus.ldr_ack === 1'b1 && o_who.size() < 20) begin
                s_lrd = 1'b1; s_laddr = AW'($urandom); nreq++;
            end
            tick();
        end
        idle(20);
        chk("t36_reached_20", 32'(o_who.size() >= 20), 32'd1);
        chk("t36_no_lost_ack", 32'(o_ntack + o_nlack), 32'(nreq));
        for (int i = 0; i < 20 && i < o_who.size(); i++)
            chk("t36_alternate", 32'(o_who[i]), 32'(i % 2 == 0));

        // cassette disabled while waiting behind the loader
        clr_obs();
        s_lrd = 1'b1; s_laddr = 25'h000040;
        tick();
        s_trd = 1'b1; s_taddr = 25'h000041;
        tick();
        s_ten = 1'b0;
        idle(12);
        chk("t37_nrd", 32'(o_nrd), 32'd1);
        chk("t37_no_tape_ack", 32'(o_ntack), 32'd0);
        chk("t37_ldr_ack", 32'(o_nlack), 32'd1);

        // cassette pulse while disabled is discarded
        clr_obs();
        s_trd = 1'b1; s_taddr = 25'h000042;
        tick();
        idle(8);
        chk("t37_dis_nrd", 32'(o_nrd), 32'd0);

        // disable during WAIT still completes
        s_ten = 1'b1;
        clr_obs();
        s_trd = 1'b1; s_taddr = 25'h000055;
        tick();
        tick();
        s_ten = 1'b0;
        idle(10);
        chk("t37_wait_ack", 32'(o_ntack), 32'd1);
        chk("t37_wait_data", 32'(bus.tape_data), 32'hE0);
        s_ten = 1'b1;

        // second pulse while pending is ignored
        clr_obs();
        s_trd = 1'b1; s_taddr = 25'h000000;
        tick();
        s_trd = 1'b1; s_taddr = 25'h000001;
        tick();
        idle(10);
        chk("t38_nrd", 32'(o_nrd), 32'd1);
        chk("t38_addr", 32'(o_rd_addr), 32'h0);
        chk("t38_nack", 32'(o_ntack), 32'd1);

        // reset during WAIT abandons the access
        clr_obs();
        s_trd = 1'b1; s_taddr = 25'h000011;
        tick();
        idle(2);
        s_rst_n = 1'b0;
        idle(2);
        chk("t39_rst_outputs", 32'({bus.mem_rd, bus.tape_ack, bus.ldr_ack, bus.busy}), 32'h0);
        chk("t39_rst_data", 32'({bus.tape_data, bus.mem_addr[7:0]}), 32'h0);
        s_rst_n = 1'b1;
        idle(8);
        chk("t39_no_ack", 32'(o_ntack), 32'd0);
        s_trd = 1'b1; s_taddr = 25'h000022;
        tick();
        idle(8);
        chk("t39_after_ack", 32'(o_ntack), 32'd1);
        chk("t39_after_data", 32'(bus.tape_data), 32'h97);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            s_trd   = ($urandom % 5 == 0);
            s_taddr = AW'($urandom);
            s_lrd   = ($urandom % 5 == 0);
            s_laddr = AW'($urandom);
            if ($urandom % 25 == 0) s_ten = ~s_ten;
            s_rst_n = ($urandom % 400 != 0);
            tick();
        end
        s_rst_n = 1'b1;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
